// File: rtl/alu4_seq_pkg.sv
// Shared types for the nibble-serial ALU controller.
// Optional feature macro: ALU4_SEQ_EARLY_EXIT_EN (see alu4_seq_ctrl).
package alu4_seq_pkg;

   localparam int NIBBLES_DEF = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_NOT = 3'b010,
      OP_AND = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_LT  = 3'b110,
      OP_EQ  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic op_is_sub(input op_e op);
      return (op == OP_SUB) || (op == OP_LT) || (op == OP_EQ);
   endfunction

endpackage

// File: rtl/alu4_slice.sv
// One 4-bit ALU slice; sub/lt/eq all compute a + ~b + cin.
// Reused by alu4_seq_ctrl once per RUN cycle.
module alu4_slice
   import alu4_seq_pkg::*;
(
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   input  op_e        op_i,
   output logic [3:0] res_o,
   output logic       cout_o,
   output logic       ovf_o
);

   logic [3:0] bb;
   logic [4:0] sum;

   always_comb begin
      bb     = op_is_sub(op_i) ? ~b_i : b_i;
      sum    = {1'b0, a_i} + {1'b0, bb} + {4'd0, cin_i};
      res_o  = sum[3:0];
      cout_o = 1'b0;
      ovf_o  = 1'b0;
      unique case (op_i)
         OP_ADD, OP_SUB, OP_LT, OP_EQ: begin
            cout_o = sum[4];
            ovf_o  = (a_i[3] == bb[3]) && (sum[3] != a_i[3]);
         end
         OP_NOT: res_o = ~a_i;
         OP_AND: res_o = a_i & b_i;
         OP_OR:  res_o = a_i | b_i;
         OP_XOR: res_o = a_i ^ b_i;
         default: res_o = sum[3:0];
      endcase
   end

endmodule

// File: rtl/alu4_seq_ctrl.sv
// Nibble-serial ALU with valid/ready request and response ports.
// Define ALU4_SEQ_EARLY_EXIT_EN to end op 111 at the first unequal nibble.
module alu4_seq_ctrl
   import alu4_seq_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [2:0]           req_op,
   input  logic [4*NIBBLES-1:0] req_a,
   input  logic [4*NIBBLES-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [4*NIBBLES-1:0] rsp_result,
   output logic                 rsp_zero,
   output logic                 rsp_carry,
   output logic                 rsp_overflow,
   output logic                 busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_e         state_q;
   op_e            op_q;
   logic [W-1:0]   a_q, b_q, result_q;
   logic [CW-1:0]  cnt_q;
   logic           cin_q, zacc_q;
   logic           rdy_q, vld_q, busy_q;
   logic           zero_q, carry_q, ovf_q;

   logic [3:0]     sl_a, sl_b, sl_res;
   logic           sl_cout, sl_ovf;
   logic [CW+1:0]  sh;
   logic           last, diff_nz, early, done_now;
   logic           zacc_d;
   logic [W-1:0]   word_d, fin_d;
   logic           carry_d, ovf_d;

   always_comb begin
      sh   = {cnt_q, 2'b00};
      sl_a = 4'(a_q >> sh);
      sl_b = 4'(b_q >> sh);
   end

   alu4_slice u_slice (
      .a_i    (sl_a),
      .b_i    (sl_b),
      .cin_i  (cin_q),
      .op_i   (op_q),
      .res_o  (sl_res),
      .cout_o (sl_cout),
      .ovf_o  (sl_ovf)
   );

   always_comb begin
      last    = (cnt_q == CW'(NIBBLES - 1));
      diff_nz = (sl_res != 4'd0);
      zacc_d  = zacc_q & ~diff_nz;
      word_d  = (result_q & ~(W'(4'hF) << sh)) | (W'(sl_res) << sh);
      fin_d   = word_d;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      unique case (op_q)
         OP_ADD, OP_SUB: begin
            carry_d = sl_cout;
            ovf_d   = sl_ovf;
         end
         OP_LT:   fin_d = W'(sl_res[3] ^ sl_ovf);
         OP_EQ:   fin_d = W'(zacc_d);
         default: fin_d = word_d;
      endcase
`ifdef ALU4_SEQ_EARLY_EXIT_EN
      // zacc_d is already 0 here, so fin_d is the "not equal" result
      early = (op_q == OP_EQ) && diff_nz;
`else
      early = 1'b0;
`endif
      done_now = last | early;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         cin_q    <= 1'b0;
         zacc_q   <= 1'b0;
         rdy_q    <= 1'b0;
         vld_q    <= 1'b0;
         busy_q   <= 1'b0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               rdy_q <= 1'b1;
               if (req_valid && rdy_q) begin
                  state_q  <= ST_RUN;
                  op_q     <= op_e'(req_op);
                  a_q      <= req_a;
                  b_q      <= req_b;
                  result_q <= '0;
                  cnt_q    <= '0;
                  cin_q    <= op_is_sub(op_e'(req_op));
                  zacc_q   <= 1'b1;
                  zero_q   <= 1'b0;
                  carry_q  <= 1'b0;
                  ovf_q    <= 1'b0;
                  rdy_q    <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            ST_RUN: begin
               cnt_q    <= cnt_q + 1'b1;
               cin_q    <= sl_cout;
               zacc_q   <= zacc_d;
               result_q <= word_d;
               if (done_now) begin
                  state_q  <= ST_DONE;
                  result_q <= fin_d;
                  zero_q   <= (fin_d == '0);
                  carry_q  <= carry_d;
                  ovf_q    <= ovf_d;
                  vld_q    <= 1'b1;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  state_q <= ST_IDLE;
                  vld_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  rdy_q   <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = rdy_q;
   assign rsp_valid    = vld_q;
   assign busy         = busy_q;
   assign rsp_result   = result_q;
   assign rsp_zero     = zero_q;
   assign rsp_carry    = carry_q;
   assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Directed bench for alu4_seq_ctrl (default NIBBLES=4).
// Honours ALU4_SEQ_EARLY_EXIT_EN for the eq latency expectation.
module tb_alu4_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [15:0] req_a = 16'd0;
   logic [15:0] req_b = 16'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_result;
   logic        rsp_zero, rsp_carry, rsp_overflow;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu4_seq_ctrl #(.NIBBLES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow),
      .busy         (busy)
   );

   // Offer one request, scramble inputs after accept, wait for rsp_valid.
   task automatic issue(input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, output int lat,
                        output logic [18:0] got);
      int n;
      @(negedge clk);
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op = 3'($urandom);
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      got = {rsp_result, rsp_zero, rsp_carry, rsp_overflow};
   endtask

   task automatic pop();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({req_ready, busy, rsp_valid, rsp_result} !== 19'd0) begin
         errors++;
         $display("FAIL reset_hold: got %h req 0", {req_ready, busy, rsp_valid, rsp_result});
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, busy, rsp_valid} !== 3'b100) begin
         errors++;
         $display("FAIL reset_release: got %b req 100", {req_ready, busy, rsp_valid});
      end
   endtask

   // Vector table: op, a, b, {result,zero,carry,ovf}, latency
   task automatic test_ops();
      logic [2:0]  op  [12];
      logic [15:0] va  [12];
      logic [15:0] vb  [12];
      logic [18:0] exp [12];
      int          el  [12];
      int          lat;
      logic [18:0] got;
      op[0]=3'd0; va[0]=16'h7FFF; vb[0]=16'h0001; exp[0]={16'h8000,3'b001}; el[0]=4;
      op[1]=3'd0; va[1]=16'hFFFF; vb[1]=16'h0001; exp[1]={16'h0000,3'b110}; el[1]=4;
      op[2]=3'd1; va[2]=16'h0000; vb[2]=16'h0001; exp[2]={16'hFFFF,3'b000}; el[2]=4;
      op[3]=3'd1; va[3]=16'h1234; vb[3]=16'h1234; exp[3]={16'h0000,3'b110}; el[3]=4;
      op[4]=3'd6; va[4]=16'h8000; vb[4]=16'h0001; exp[4]={16'h0001,3'b000}; el[4]=4;
      op[5]=3'd6; va[5]=16'h0001; vb[5]=16'h8000; exp[5]={16'h0000,3'b100}; el[5]=4;
      op[6]=3'd7; va[6]=16'h1234; vb[6]=16'h1234; exp[6]={16'h0001,3'b000}; el[6]=4;
`ifdef ALU4_SEQ_EARLY_EXIT_EN
      op[7]=3'd7; va[7]=16'h1235; vb[7]=16'h1234; exp[7]={16'h0000,3'b100}; el[7]=1;
`else
      op[7]=3'd7; va[7]=16'h1235; vb[7]=16'h1234; exp[7]={16'h0000,3'b100}; el[7]=4;
`endif
      op[8]=3'd2; va[8]=16'h00FF; vb[8]=16'h1234; exp[8]={16'hFF00,3'b000}; el[8]=4;
      op[9]=3'd3; va[9]=16'hF0F0; vb[9]=16'hFF00; exp[9]={16'hF000,3'b000}; el[9]=4;
      op[10]=3'd4; va[10]=16'h0F0F; vb[10]=16'h00F0; exp[10]={16'h0FFF,3'b000}; el[10]=4;
      op[11]=3'd5; va[11]=16'hA5A5; vb[11]=16'hA5A5; exp[11]={16'h0000,3'b100}; el[11]=4;
      for (int i = 0; i < 12; i++) begin
         issue(op[i], va[i], vb[i], lat, got);
         checks++;
         if (got !== exp[i]) begin
            errors++;
            $display("FAIL op%0d_value: got %h req %h", i, got, exp[i]);
         end
         checks++;
         if (lat !== el[i]) begin
            errors++;
            $display("FAIL op%0d_latency: got %0d req %0d", i, lat, el[i]);
         end
         pop();
      end
   endtask

   task automatic test_back_to_back();
      int          lat;
      logic [18:0] got;
      issue(3'd0, 16'h0001, 16'h0002, lat, got);
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd1; req_a = 16'h0005; req_b = 16'h0003;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({rsp_valid, req_ready, busy, rsp_result, rsp_zero, rsp_carry, rsp_overflow}
             !== {3'b101, 16'h0003, 3'b000}) begin
            errors++;
            $display("FAIL stall%0d: got v%b r%b b%b %h req v1 r0 b1 0003", i,
                     rsp_valid, req_ready, busy, rsp_result);
         end
      end
      @(negedge clk); rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL handshake: got v%b r%b req v0 r1", rsp_valid, req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if ({busy, req_ready} !== 2'b10) begin
         errors++;
         $display("FAIL next_accept: got b%b r%b req b1 r0", busy, req_ready);
      end
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if ({rsp_result, rsp_zero, rsp_carry, rsp_overflow} !== {16'h0002, 3'b010}
          || lat !== 4) begin
         errors++;
         $display("FAIL second_req: got %h lat %0d req 0002 c1 lat 4", rsp_result, lat);
      end
      pop();
   endtask

   task automatic test_reset_midrun();
      int seen;
      @(negedge clk);
      req_op = 3'd0; req_a = 16'h7FFF; req_b = 16'h0001; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, busy, req_ready, rsp_result, rsp_zero, rsp_carry, rsp_overflow}
          !== 22'd0) begin
         errors++;
         $display("FAIL midrun_reset: got v%b b%b r%b %h req all 0",
                  rsp_valid, busy, req_ready, rsp_result);
      end
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen !== 0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL no_stale_rsp: got %0d valids r%b req 0 valids r1", seen, req_ready);
      end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_back_to_back();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu4_seq_ctrl.md
ALU4_SEQ_CTRL -- requirements
Module: alu4_seq_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand; word width W = 4*NIBBLES.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  request offered.
REQ-005 SHALL have port req_ready  out  1  request accepted when both high.
REQ-006 SHALL have ports req_op in 3, req_a in W, req_b in W: opcode and operands.
REQ-007 SHALL have port rsp_valid  out  1  result available.
REQ-008 SHALL have port rsp_ready  in  1  consumer takes result when both high.
REQ-009 SHALL have ports rsp_result out W, rsp_zero/rsp_carry/rsp_overflow out 1 each.
REQ-010 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-011 SHALL decode req_op: 000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed a<b, 111 a==b.
REQ-012 SHALL use FSM IDLE -> RUN on accept; RUN -> DONE after nibble NIBBLES-1; DONE -> IDLE on rsp_valid&&rsp_ready.
REQ-013 SHALL drive req_ready=1 only in IDLE, rsp_valid=1 only in DONE; no accept in the response-handshake cycle.
REQ-014 SHALL capture op, a, b at accept; later input changes SHALL be ignored.
REQ-015 SHALL process one nibble per RUN cycle, LSB nibble first, via 2-bit-wide-enough counter 0..NIBBLES-1, writing the nibble into result register at that index.
REQ-016 SHALL chain carry between nibbles; add cin0=0; sub/lt/eq compute a+~b with cin0=1.
REQ-017 SHALL give rsp_valid high NIBBLES cycles after the accept edge (4 for default).
REQ-018 SHALL set rsp_carry = final-nibble carry-out and rsp_overflow = final-nibble signed overflow for add/sub; both 0 for not/and/or/xor/lt/eq.
REQ-019 SHALL set lt result = {W-1 zeros, sign^overflow of full subtraction}; eq result = {W-1 zeros, all difference nibbles zero}.
REQ-020 SHALL set rsp_zero = (rsp_result == 0) for every op.
REQ-021 SHALL hold all rsp_* outputs stable while rsp_valid=1 and rsp_ready=0.
REQ-022 SHALL ignore req_b for op 010.

Reset
REQ-023 SHALL on rst_n low immediately force IDLE, counter 0, result/flags 0, rsp_valid 0, busy 0, req_ready 0 during reset, 1 after release.
REQ-024 SHALL drop any in-flight operation on reset; no response produced for it.

Configuration
REQ-025 SHALL honour macro ALU4_SEQ_EARLY_EXIT_EN: when defined, op 111 moves RUN -> DONE in the cycle a difference nibble is nonzero (result 0, latency = nibble index+1); when undefined, all ops take exactly NIBBLES cycles.

Structure
REQ-026 SHALL place opcode enum, FSM state enum and NIBBLES default in shared package alu4_seq_pkg.
REQ-027 SHALL instantiate one combinational sub-module alu4_slice (4-bit a, b, cin, op -> result, cout, ovf) reused every RUN cycle.

Verification
REQ-028 add 0x7FFF+0x0001 -> result 0x8000, overflow 1, carry 0, zero 0, rsp_valid 4 cycles after accept.
REQ-029 sub 0x0000-0x0001 -> 0xFFFF, carry 0, overflow 0; sub 0x1234-0x1234 -> 0x0000, zero 1, carry 1.
REQ-030 lt 0x8000,0x0001 -> 0x0001; lt 0x0001,0x8000 -> 0x0000, zero 1.
REQ-031 eq 0x1234,0x1234 -> 0x0001 after 4 cycles; eq 0x1235,0x1234 -> 0x0000 after 1 cycle with ALU4_SEQ_EARLY_EXIT_EN, 4 without.
REQ-032 rsp_ready held low 3 cycles in DONE -> outputs stable, req_ready 0; next request accepted the cycle after handshake.
REQ-033 rst_n low during RUN nibble 2 -> IDLE, outputs 0 asynchronously; no rsp_valid for that request.
